mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/rr_arbiter2.sv | 19 +
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

    // Arbiter ownership state: nobody, instruction bus, or data bus.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    // Default number of slave wait cycles tolerated before a transfer is aborted.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // The instruction bus always fetches full words.
    localparam logic [3:0] IBUS_BYTEENABLE = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two requesting masters (ibus, dbus), the arbiter and one slave.
//
// Handshake: a master raises its request (ibus_read, or dbus_read/dbus_write)
// with address/data stable and holds it until it sees its stall low in a cycle;
// that cycle is the completion cycle and rddata is valid in it. Towards the slave,
// a transfer completes in a cycle where mem_read or mem_write is high and
// mem_waitrequest is low.
interface mem_bus_arbiter_if;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;

    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_wrdata;
    logic [31:0] dbus_rddata;
    logic        dbus_stall;

    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_waitrequest;

    logic        bus_error;

    // Arbiter side: serves the masters and drives the slave.
    modport slave (
        input  ibus_address, ibus_read,
        output ibus_rddata, ibus_stall,
        input  dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
        output dbus_rddata, dbus_stall,
        output mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
        input  mem_rddata, mem_waitrequest,
        output bus_error
    );

    // Environment side: the two masters plus the memory slave.
    modport master (
        output ibus_address, ibus_read,
        input  ibus_rddata, ibus_stall,
        output dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
        input  dbus_rddata, dbus_stall,
        input  mem_address, mem_byteenable, mem_read, mem_write, mem_wrdata,
        output mem_rddata, mem_waitrequest,
        input  bus_error
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin tie-break: a lone requester wins, a tie goes to the
// index that was not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] grant
);

    // One-hot grant from the request pair and the last-served index.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = last_served ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction bus and a data bus onto one memory slave.
// Requests are latched on the grant edge so the slave sees stable values even
// if the master withdraws; a wait counter aborts transfers the slave never ends.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_bus_arbiter_if.slave bus,
    output state_t           dbg_state
);

    // Wait-count value that marks the last tolerated wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q;
    logic        last_q;          // index last served: 1 = dbus, 0 = ibus
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] wrdata_q;
    logic [31:0] ibus_rd_q;
    logic [31:0] dbus_rd_q;

    logic        ibus_req;
    logic        dbus_req;
    logic [1:0]  grant;           // bit 1 = dbus, bit 0 = ibus
    logic        granted;
    logic        timeout_hit;
    logic        done;
    logic        done_i;
    logic        done_d;
    logic [31:0] cpl_data;

    assign ibus_req    = bus.ibus_read;
    assign dbus_req    = bus.dbus_read | bus.dbus_write;
    assign granted     = (state_q != IDLE);
    assign timeout_hit = granted & bus.mem_waitrequest & (wait_q == WAIT_LAST);
    assign done        = granted & (~bus.mem_waitrequest | timeout_hit);
    assign done_i      = done & (state_q == GRANT_I);
    assign done_d      = done & (state_q == GRANT_D);
    assign cpl_data    = timeout_hit ? 32'h0 : bus.mem_rddata;

    rr_arbiter2 u_rr (
        .req         ({dbus_req, ibus_req}),
        .last_served (last_q),
        .grant       (grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, back to IDLE once the transfer ends or aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    state_d = GRANT_D;
                end else if (grant[0]) begin
                    state_d = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's request on the grant edge; clear it when the transfer ends
    // so the slave outputs are zero whenever the arbiter is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q   <= '0;
            last_q   <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wrdata_q <= '0;
        end else if (state_q == IDLE) begin
            wait_q <= '0;
            if (grant[1]) begin
                addr_q   <= bus.dbus_address;
                be_q     <= bus.dbus_byteenable;
                rd_q     <= bus.dbus_read & ~bus.dbus_write;
                wr_q     <= bus.dbus_write;
                wrdata_q <= bus.dbus_wrdata;
                last_q   <= 1'b1;
            end else if (grant[0]) begin
                addr_q   <= bus.ibus_address;
                be_q     <= IBUS_BYTEENABLE;
                rd_q     <= 1'b1;
                wr_q     <= 1'b0;
                wrdata_q <= '0;
                last_q   <= 1'b0;
            end
        end else if (done) begin
            wait_q   <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wrdata_q <= '0;
        end else begin
            wait_q <= wait_q + 8'd1;
        end
    end

    // Remember the last delivered read data; withdrawn requests and writes leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibus_rd_q <= '0;
            dbus_rd_q <= '0;
        end else begin
            if (done_i & ibus_req) begin
                ibus_rd_q <= cpl_data;
            end
            if (done_d & dbus_req & rd_q) begin
                dbus_rd_q <= cpl_data;
            end
        end
    end

    assign bus.ibus_rddata    = (done_i & ibus_req) ? cpl_data : ibus_rd_q;
    assign bus.ibus_stall     = ibus_req & ~done_i;
    assign bus.dbus_rddata    = (done_d & dbus_req & rd_q) ? cpl_data : dbus_rd_q;
    assign bus.dbus_stall     = dbus_req & ~done_d;
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_wrdata     = wrdata_q;
    assign bus.bus_error      = timeout_hit;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: single-transfer vector table, hand-written
// multi-cycle sequences, then randomized traffic against an ownership model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_if();
  state_t dbg_state;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_ird;
  logic [31:0] exp_drd;
  logic [1:0]  exp_q[$];

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;
  vec_t vecs[6];

  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } txn_t;

  // reference model state (1 = ibus, 2 = dbus, 0 = nobody)
  int          m_owner, m_owner_n, m_last, m_last_n;
  txn_t        m_cur, m_cur_n;
  logic [31:0] m_ird, m_drd, e_ird, e_drd;
  logic        e_istall, e_dstall, e_read, e_write;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  bit          prev_i_done, prev_d_done;
  int          w_run;

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus_if.ibus_address    = '0;
    bus_if.ibus_read       = 1'b0;
    bus_if.dbus_address    = '0;
    bus_if.dbus_byteenable = '0;
    bus_if.dbus_read       = 1'b0;
    bus_if.dbus_write      = 1'b0;
    bus_if.dbus_wrdata     = '0;
    bus_if.mem_rddata      = '0;
    bus_if.mem_waitrequest = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    check("rst_mem_read", bus_if.mem_read, 1'b0);
    check("rst_mem_write", bus_if.mem_write, 1'b0);
    check("rst_mem_address", bus_if.mem_address, 32'h0);
    check("rst_mem_be", bus_if.mem_byteenable, 4'h0);
    check("rst_mem_wrdata", bus_if.mem_wrdata, 32'h0);
    check("rst_bus_error", bus_if.bus_error, 1'b0);
    check("rst_ibus_rddata", bus_if.ibus_rddata, 32'h0);
    check("rst_dbus_rddata", bus_if.dbus_rddata, 32'h0);
    check("rst_stalls", {bus_if.ibus_stall, bus_if.dbus_stall}, 2'b00);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ird = '0;
    exp_drd = '0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // One isolated transfer from a table record, with latency and data checks.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    bit   fin;
    logic stall_now;
    cycle();
    if (v.is_d) begin
      bus_if.dbus_address    = v.addr;
      bus_if.dbus_byteenable = v.be;
      bus_if.dbus_read       = v.rd;
      bus_if.dbus_write      = v.wr;
      bus_if.dbus_wrdata     = v.wdata;
    end else begin
      bus_if.ibus_address = v.addr;
      bus_if.ibus_read    = 1'b1;
    end
    bus_if.mem_waitrequest = 1'b1;
    @(negedge clk);
    stall_now = v.is_d ? bus_if.dbus_stall : bus_if.ibus_stall;
    check($sformatf("vec%0d_req_stall", idx), stall_now, 1'b1);
    check($sformatf("vec%0d_req_strobe", idx), {bus_if.mem_read, bus_if.mem_write}, 2'b00);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 300) begin
      cycle();
      bus_if.mem_waitrequest = (cyc < v.waits);
      bus_if.mem_rddata      = v.rdata;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check($sformatf("vec%0d_addr", idx), bus_if.mem_address, v.addr);
        check($sformatf("vec%0d_be", idx), bus_if.mem_byteenable, v.exp_be);
        check($sformatf("vec%0d_strobe", idx), {bus_if.mem_read, bus_if.mem_write}, {v.exp_rd, v.exp_wr});
        if (v.exp_wr) check($sformatf("vec%0d_wrdata", idx), bus_if.mem_wrdata, v.wdata);
      end
      stall_now = v.is_d ? bus_if.dbus_stall : bus_if.ibus_stall;
      if (!stall_now) begin
        fin = 1'b1;
        check($sformatf("vec%0d_cpl_strobe", idx), {bus_if.mem_read, bus_if.mem_write}, {v.exp_rd, v.exp_wr});
        if (v.is_d) begin
          if (v.exp_rd) exp_drd = v.rdata;
          check($sformatf("vec%0d_drddata", idx), bus_if.dbus_rddata, exp_drd);
        end else begin
          exp_ird = v.rdata;
          check($sformatf("vec%0d_irddata", idx), bus_if.ibus_rddata, exp_ird);
        end
      end
    end
    check($sformatf("vec%0d_latency", idx), cyc, v.waits + 1);
    cycle();
    drive_idle();
    bus_if.mem_rddata = 32'hBAD0_BAD0;
    @(negedge clk);
    check($sformatf("vec%0d_back_idle", idx), 32'(dbg_state), 32'(IDLE));
    check($sformatf("vec%0d_idle_strobe", idx), {bus_if.mem_read, bus_if.mem_write}, 2'b00);
    check($sformatf("vec%0d_hold_i", idx), bus_if.ibus_rddata, exp_ird);
    check($sformatf("vec%0d_hold_d", idx), bus_if.dbus_rddata, exp_drd);
  endtask

  // ---------------- reference model ----------------
  // Who owns the bus, what was latched, and what each master sees this cycle.
  function automatic void model_eval();
    bit i_req, d_req, fin;
    int pick;
    i_req    = bus_if.ibus_read;
    d_req    = bus_if.dbus_read | bus_if.dbus_write;
    fin      = (m_owner != 0) && !bus_if.mem_waitrequest;
    e_read   = (m_owner != 0) ? m_cur.rd : 1'b0;
    e_write  = (m_owner != 0) ? m_cur.wr : 1'b0;
    e_addr   = (m_owner != 0) ? m_cur.addr : 32'h0;
    e_be     = (m_owner != 0) ? m_cur.be : 4'h0;
    e_wdata  = (m_owner != 0) ? m_cur.wdata : 32'h0;
    e_istall = i_req && !(fin && m_owner == 1);
    e_dstall = d_req && !(fin && m_owner == 2);
    e_ird    = m_ird;
    e_drd    = m_drd;
    if (fin && m_owner == 1 && i_req) e_ird = bus_if.mem_rddata;
    if (fin && m_owner == 2 && d_req && m_cur.rd) e_drd = bus_if.mem_rddata;
    m_cur_n   = m_cur;
    m_owner_n = m_owner;
    m_last_n  = m_last;
    if (m_owner != 0) begin
      if (fin) m_owner_n = 0;
    end else begin
      pick = 0;
      if (i_req && d_req) pick = (m_last == 2) ? 1 : 2;
      else if (i_req)     pick = 1;
      else if (d_req)     pick = 2;
      if (pick == 1) m_cur_n = '{who: 1, addr: bus_if.ibus_address, be: 4'hF, rd: 1'b1, wr: 1'b0, wdata: 32'h0};
      if (pick == 2) m_cur_n = '{who: 2, addr: bus_if.dbus_address, be: bus_if.dbus_byteenable,
                                 rd: bus_if.dbus_read & ~bus_if.dbus_write, wr: bus_if.dbus_write,
                                 wdata: bus_if.dbus_wrdata};
      if (pick != 0) begin
        m_owner_n = pick;
        m_last_n  = pick;
      end
    end
    prev_i_done = i_req && !e_istall;
    prev_d_done = d_req && !e_dstall;
  endfunction

  function automatic void model_commit();
    m_owner = m_owner_n;
    m_cur   = m_cur_n;
    m_last  = m_last_n;
    m_ird   = e_ird;
    m_drd   = e_drd;
  endfunction

  task automatic drive_random();
    int op;
    bus_if.mem_waitrequest = (w_run < 6) && ($urandom_range(0, 1) == 1);
    w_run = bus_if.mem_waitrequest ? w_run + 1 : 0;
    bus_if.mem_rddata = $urandom();
    if (bus_if.ibus_read) begin
      if (prev_i_done || $urandom_range(0, 15) == 0) begin
        bus_if.ibus_read    = ($urandom_range(0, 3) == 0);
        bus_if.ibus_address = $urandom() & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bus_if.ibus_read    = 1'b1;
      bus_if.ibus_address = $urandom() & 32'hFFFF_FFFC;
    end
    if (bus_if.dbus_read || bus_if.dbus_write) begin
      if (prev_d_done || $urandom_range(0, 15) == 0) begin
        bus_if.dbus_read  = 1'b0;
        bus_if.dbus_write = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      op = $urandom_range(0, 2);
      bus_if.dbus_read       = (op != 1);
      bus_if.dbus_write      = (op != 0);
      bus_if.dbus_address    = $urandom() & 32'hFFFF_FFFC;
      bus_if.dbus_byteenable = 4'($urandom_range(0, 15));
      bus_if.dbus_wrdata     = $urandom();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int obs;
    int err_cyc;
    int pulses;
    int cyc;
    bit fin;
    rst_n = 1'b0;
    drive_idle();
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'h0,    32'h0,         3, 32'h3C01_0000, 4'b1111, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, 4'b0001, 32'h0,         0, 32'hDEAD_BEEF, 4'b0001, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_2004, 4'b1100, 32'hCAFE_F00D, 2, 32'h1111_1111, 4'b1100, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_300C, 4'b1111, 32'h1111_2222, 1, 32'h9999_9999, 4'b1111, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'h0,    32'h0,         0, 32'h0123_4567, 4'b1111, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_5550, 4'b1010, 32'h0,         5, 32'hA5A5_A5A5, 4'b1010, 1'b1, 1'b0};
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Simultaneous requests after reset: dbus write first, then ibus read.
    do_reset();
    cycle();
    bus_if.dbus_address = 32'h0000_4000; bus_if.dbus_byteenable = 4'b0011;
    bus_if.dbus_wrdata  = 32'h1234_5678; bus_if.dbus_write = 1'b1;
    bus_if.ibus_address = 32'h8000_0100; bus_if.ibus_read = 1'b1;
    bus_if.mem_rddata   = 32'h55AA_55AA;
    @(negedge clk);
    check("tie_req_stalls", {bus_if.ibus_stall, bus_if.dbus_stall}, 2'b11);
    cycle();
    @(negedge clk);
    check("tie_d_write", {bus_if.mem_read, bus_if.mem_write}, 2'b01);
    check("tie_d_be", bus_if.mem_byteenable, 4'b0011);
    check("tie_d_wrdata", bus_if.mem_wrdata, 32'h1234_5678);
    check("tie_d_stalls", {bus_if.ibus_stall, bus_if.dbus_stall}, 2'b10);
    cycle();
    bus_if.dbus_write = 1'b0;
    @(negedge clk);
    check("tie_gap_strobe", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
    cycle();
    @(negedge clk);
    check("tie_i_read", {bus_if.mem_read, bus_if.mem_write}, 2'b10);
    check("tie_i_be", bus_if.mem_byteenable, 4'b1111);
    check("tie_i_addr", bus_if.mem_address, 32'h8000_0100);
    check("tie_i_stall", bus_if.ibus_stall, 1'b0);
    check("tie_i_rddata", bus_if.ibus_rddata, 32'h55AA_55AA);
    exp_ird = 32'h55AA_55AA;
    cycle();
    bus_if.ibus_read = 1'b0;

    // Continuous requests from both masters alternate, starting with dbus.
    cycle();
    bus_if.dbus_write = 1'b1;
    bus_if.ibus_read  = 1'b1;
    exp_q = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 30) begin
      cycle();
      @(negedge clk);
      cyc++;
      obs = bus_if.mem_write ? 2 : (bus_if.mem_read ? 1 : 0);
      if (obs != 0) check("alt_grant", obs, exp_q.pop_front());
    end
    check("alt_all_seen", exp_q.size(), 0);
    cycle();
    drive_idle();
    cycle();

    // Slave never answers: abort with a single bus_error pulse and zero data.
    bus_if.dbus_address = 32'h0000_5000; bus_if.dbus_byteenable = 4'hF;
    bus_if.dbus_read = 1'b1; bus_if.mem_waitrequest = 1'b1; bus_if.mem_rddata = 32'hFFFF_FFFF;
    @(negedge clk);
    cyc = 0; fin = 1'b0; err_cyc = -1; pulses = 0;
    while (!fin && cyc < 400) begin
      cycle();
      @(negedge clk);
      cyc++;
      if (bus_if.bus_error) begin
        pulses++;
        err_cyc = cyc;
      end
      if (!bus_if.dbus_stall) begin
        fin = 1'b1;
        check("tmo_rddata", bus_if.dbus_rddata, 32'h0);
      end
    end
    check("tmo_error_cycle", err_cyc, 255);
    check("tmo_done_cycle", cyc, 255);
    cycle();
    bus_if.dbus_read = 1'b0;
    @(negedge clk);
    check("tmo_state_idle", 32'(dbg_state), 32'(IDLE));
    check("tmo_rddata_hold", bus_if.dbus_rddata, 32'h0);
    repeat (3) begin
      cycle();
      @(negedge clk);
      if (bus_if.bus_error) pulses++;
    end
    check("tmo_single_pulse", pulses, 1);
    exp_drd = 32'h0;

    // ibus withdraws after its grant: slave read still finishes, data discarded.
    cycle();
    bus_if.mem_waitrequest = 1'b1; bus_if.mem_rddata = 32'h7777_7777;
    bus_if.ibus_address = 32'h0000_6000; bus_if.ibus_read = 1'b1;
    cycle();
    @(negedge clk);
    check("drop_granted", bus_if.mem_read, 1'b1);
    cycle();
    bus_if.ibus_read = 1'b0;
    @(negedge clk);
    check("drop_read_held", bus_if.mem_read, 1'b1);
    check("drop_addr_held", bus_if.mem_address, 32'h0000_6000);
    check("drop_no_stall", bus_if.ibus_stall, 1'b0);
    cycle();
    cycle();
    bus_if.mem_waitrequest = 1'b0;
    @(negedge clk);
    check("drop_cpl_read", bus_if.mem_read, 1'b1);
    check("drop_discard", bus_if.ibus_rddata, exp_ird);
    cycle();
    bus_if.dbus_address = 32'h0000_7000; bus_if.dbus_read = 1'b1; bus_if.mem_rddata = 32'h3141_5926;
    @(negedge clk);
    check("drop_idle_gap", bus_if.mem_read, 1'b0);
    cycle();
    @(negedge clk);
    check("drop_next_addr", bus_if.mem_address, 32'h0000_7000);
    check("drop_next_done", bus_if.dbus_stall, 1'b0);
    check("drop_next_data", bus_if.dbus_rddata, 32'h3141_5926);
    check("drop_keep_i", bus_if.ibus_rddata, exp_ird);
    cycle();
    bus_if.dbus_read = 1'b0;

    // Reset in the middle of a waiting transfer.
    cycle();
    bus_if.dbus_address = 32'h0000_8000; bus_if.dbus_read = 1'b1; bus_if.mem_waitrequest = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("rstmid_busy", bus_if.mem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_read_low", bus_if.mem_read, 1'b0);
    check("rstmid_addr_low", bus_if.mem_address, 32'h0);
    check("rstmid_no_error", bus_if.bus_error, 1'b0);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    check("rstmid_drd_clear", bus_if.dbus_rddata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.ibus_address = 32'h0000_9000; bus_if.ibus_read = 1'b1;
    bus_if.mem_waitrequest = 1'b0; bus_if.mem_rddata = 32'h2468_ACE0;
    cycle();
    @(negedge clk);
    check("rstmid_tie_d", bus_if.mem_address, 32'h0000_8000);
    check("rstmid_tie_stalls", {bus_if.ibus_stall, bus_if.dbus_stall}, 2'b10);
    check("rstmid_tie_data", bus_if.dbus_rddata, 32'h2468_ACE0);
    cycle();
    bus_if.dbus_read = 1'b0;
    cycle();
    @(negedge clk);
    check("rstmid_then_i", bus_if.mem_address, 32'h0000_9000);
    check("rstmid_i_data", bus_if.ibus_rddata, 32'h2468_ACE0);
    cycle();
    bus_if.ibus_read = 1'b0;

    // Randomized traffic against the ownership model.
    do_reset();
    m_owner = 0; m_owner_n = 0; m_last = 1; m_last_n = 1;
    m_cur = '{who: 0, addr: 32'h0, be: 4'h0, rd: 1'b0, wr: 1'b0, wdata: 32'h0};
    m_cur_n = m_cur;
    m_ird = '0; m_drd = '0; e_ird = '0; e_drd = '0;
    prev_i_done = 1'b0; prev_d_done = 1'b0; w_run = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      model_commit();
      #1;
      drive_random();
      model_eval();
      @(negedge clk);
      check("rnd_ibus_stall", bus_if.ibus_stall, e_istall);
      check("rnd_dbus_stall", bus_if.dbus_stall, e_dstall);
      check("rnd_strobes", {bus_if.mem_read, bus_if.mem_write}, {e_read, e_write});
      check("rnd_address", bus_if.mem_address, e_addr);
      check("rnd_be", bus_if.mem_byteenable, e_be);
      if (e_write) check("rnd_wrdata", bus_if.mem_wrdata, e_wdata);
      check("rnd_ibus_rddata", bus_if.ibus_rddata, e_ird);
      check("rnd_dbus_rddata", bus_if.dbus_rddata, e_drd);
      check("rnd_bus_error", bus_if.bus_error, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before the end of the test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
